icache_dm: RTL and testbench

Direct-mapped, read-only instruction cache. It is the responder end of the IF1 fetch interface: IF1 presents a valid PC, and this block returns the instruction with a ready flag, or asserts stall while it refills. On a miss it acts as a burst-read initiator toward the memory side. It sits between the IF0_IF1 register/IF1 stage and the memory/bus arbiter.

---
 rtl/icache_dm.sv | 178 +++++++++++++++++
 tb/tb_icache_dm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path toward IF1,
// single-outstanding burst refill toward the memory side.
module icache_dm #(
  parameter int WORD       = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [WORD-1:0] req_addr,
  output logic            resp_ready,
  output logic [WORD-1:0] resp_inst,
  output logic            stall,
  input  logic            inval,
  output logic            mem_rd_req,
  output logic [WORD-1:0] mem_rd_addr,
  input  logic            mem_rd_ack,
  input  logic            mem_rd_valid,
  input  logic [WORD-1:0] mem_rd_data,
  input  logic            mem_rd_last
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = OFF_W + IDX_W + 2;
  localparam int TAG_W   = WORD - TAG_LSB;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REFILL, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [WORD-1:0]    r_data [SETS][LINE_WORDS];
  logic [WORD-1:0]    r_line_addr;
  logic [OFF_W-1:0]   r_cap_off;
  logic [OFF_W-1:0]   r_beat_cnt;
  logic               r_wrapped;

  logic [OFF_W-1:0]   w_off;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_cap_idx;
  logic [TAG_W-1:0]   w_cap_tag;
  logic               w_hit;
  logic               w_line_match;
  logic               w_miss;
  logic               w_beat;
  logic               w_install;

  assign w_off        = req_addr[OFF_W+1:2];
  assign w_idx        = req_addr[TAG_LSB-1:OFF_W+2];
  assign w_tag        = req_addr[WORD-1:TAG_LSB];
  assign w_cap_idx    = r_line_addr[TAG_LSB-1:OFF_W+2];
  assign w_cap_tag    = r_line_addr[WORD-1:TAG_LSB];
  assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line_match = (req_addr[WORD-1:OFF_W+2] == r_line_addr[WORD-1:OFF_W+2]);
  assign w_beat       = (r_state == S_REFILL) && mem_rd_valid;
  assign w_install    = w_beat && mem_rd_last;
  assign mem_rd_addr  = r_line_addr;

  // Next-state and fetch-side outputs; everything reads as idle while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    resp_ready  = 1'b0;
    resp_inst   = {WORD{1'b0}};
    stall       = 1'b0;
    mem_rd_req  = 1'b0;
    w_miss      = 1'b0;
    if (!rst) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && w_hit) begin
            resp_ready = 1'b1;
            resp_inst  = r_data[w_idx][w_off];
          end else if (req_valid) begin
            stall       = 1'b1;
            w_miss      = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_REQ: begin
          stall      = 1'b1;
          mem_rd_req = 1'b1;
          if (mem_rd_ack) begin
            w_state_nxt = S_REFILL;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
        S_REFILL: begin
          stall = 1'b1;
          if (w_install) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_REFILL;
          end
        end
        S_DONE: begin
          // Only the word that caused the miss is presented; a moved PC re-misses from IDLE.
          if (req_valid && w_line_match) begin
            resp_ready = 1'b1;
            resp_inst  = r_data[w_cap_idx][r_cap_off];
          end else begin
            resp_ready = 1'b0;
          end
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Miss capture and refill beat bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line_addr <= {WORD{1'b0}};
      r_cap_off   <= {OFF_W{1'b0}};
      r_beat_cnt  <= {OFF_W{1'b0}};
      r_wrapped   <= 1'b0;
    end else begin
      if (w_miss) begin
        r_line_addr <= {w_tag, w_idx, {(OFF_W+2){1'b0}}};
        r_cap_off   <= w_off;
      end
      if (r_state == S_REQ) begin
        r_beat_cnt <= {OFF_W{1'b0}};
        r_wrapped  <= 1'b0;
      end else if (w_beat && !r_wrapped) begin
        r_beat_cnt <= r_beat_cnt + {{(OFF_W-1){1'b0}}, 1'b1};
        if (r_beat_cnt == OFF_W'(LINE_WORDS - 1)) begin
          r_wrapped <= 1'b1;
        end
      end
    end
  end

  // Valid bits: inval clears everything, but a line completing this edge is still installed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= {SETS{1'b0}};
    end else begin
      if (inval) begin
        r_valid <= {SETS{1'b0}};
      end
      if (w_install) begin
        r_valid[w_cap_idx] <= 1'b1;
      end
    end
  end

  // Data and tag arrays; beats land directly in the target set, words missed by an early last keep old data.
  always_ff @(posedge clk) begin
    if (w_beat && !r_wrapped) begin
      r_data[w_cap_idx][r_beat_cnt] <= mem_rd_data;
    end
    if (w_install) begin
      r_tag[w_cap_idx] <= w_cap_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized fetches
// checked against a set-array model of a direct-mapped cache.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic        stall;
  logic        inval = 1'b0;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ack = 1'b0;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = 32'h0;
  logic        mem_rd_last = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what each of the 64 sets holds.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] m_data  [64][4];

  icache_dm dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .resp_ready(resp_ready), .resp_inst(resp_inst), .stall(stall), .inval(inval),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd64);
  endfunction

  function automatic int off_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd4);
  endfunction

  function automatic logic [21:0] tag_of(input logic [31:0] a);
    return 22'(a / 32'd1024);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic model_install(input logic [31:0] a, input logic [127:0] d);
    m_valid[idx_of(a)] = 1'b1;
    m_tag[idx_of(a)]   = tag_of(a);
    for (int k = 0; k < 4; k++) m_data[idx_of(a)][k] = d[32*k +: 32];
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) m_valid[s] = 1'b0;
  endtask

  // Memory responder for one miss, called in the IDLE miss cycle. Holds ack low for aw
  // request cycles, then streams four beats; returns cycles until stall first drops.
  task automatic serve_miss(input logic [31:0] line, input int aw, input logic [127:0] d,
                            input bit drop, output int lat, output bit req_ok,
                            output logic done_rdy, output logic [31:0] done_inst);
    int  waited = 0;
    int  beats  = 0;
    bit  acked  = 1'b0;
    bit  done   = 1'b0;
    lat = 0; req_ok = 1'b1; done_rdy = 1'b0; done_inst = 32'h0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_last = 1'b0; mem_rd_data = 32'h0;
      if (!acked) begin
        if (mem_rd_req !== 1'b1 || mem_rd_addr !== line) req_ok = 1'b0;
        if (mem_rd_req === 1'b1) begin
          if (waited == aw) begin
            mem_rd_ack = 1'b1;
            acked = 1'b1;
          end else begin
            waited++;
          end
        end
      end else if (beats < 4) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = d[32*beats +: 32];
        mem_rd_last  = (beats == 3);
        beats++;
        if (drop && beats == 2) req_valid = 1'b0;
      end
      #1;
      if (stall !== 1'b1) begin
        done = 1'b1;
        done_rdy = resp_ready;
        done_inst = resp_inst;
      end
    end
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_last = 1'b0; mem_rd_data = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_tests++; if (resp_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", resp_ready); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_tests++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_memreq got=%b exp=0", mem_rd_req); end
    n_tests++; if (mem_rd_addr !== 32'h0) begin n_fail++; $display("FAIL reset_memaddr got=%h exp=0", mem_rd_addr); end
    n_tests++; if (resp_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", resp_inst); end
  endtask

  // Issue a request expected to miss and run its refill; checks stall, request, latency and DONE word.
  task automatic miss_fill(input string nm, input logic [31:0] a, input int aw,
                           input logic [127:0] d);
    int lat; bit rok; logic rdy; logic [31:0] ins;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a;
    #1;
    n_tests++; if (stall !== 1'b1 || resp_ready !== 1'b0) begin n_fail++; $display("FAIL %s_miss_stall got stall=%b ready=%b exp stall=1 ready=0", nm, stall, resp_ready); end
    serve_miss(a & 32'hFFFF_FFF0, aw, d, 1'b0, lat, rok, rdy, ins);
    n_tests++; if (!rok) begin n_fail++; $display("FAIL %s_memreq got unstable/wrong req exp addr=%h", nm, a & 32'hFFFF_FFF0); end
    n_tests++; if (lat != 2 + aw + 4) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, 2 + aw + 4); end
    n_tests++; if (rdy !== 1'b1 || ins !== d[32*off_of(a) +: 32]) begin n_fail++; $display("FAIL %s_done got ready=%b inst=%h exp ready=1 inst=%h", nm, rdy, ins, d[32*off_of(a) +: 32]); end
    model_install(a, d);
  endtask

  task automatic expect_hit(input string nm, input logic [31:0] a);
    logic [31:0] exp_w;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a;
    #1;
    exp_w = m_data[idx_of(a)][off_of(a)];
    n_tests++; if (resp_ready !== 1'b1 || stall !== 1'b0 || resp_inst !== exp_w) begin n_fail++; $display("FAIL %s_hit got ready=%b stall=%b inst=%h exp ready=1 stall=0 inst=%h", nm, resp_ready, stall, resp_inst, exp_w); end
  endtask

  task automatic test_first_miss();
    miss_fill("first", 32'h1C00_0000, 0, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
  endtask

  task automatic test_hit();
    expect_hit("hitA3", 32'h1C00_000C);
  endtask

  task automatic test_conflict();
    miss_fill("conflictB", 32'h1C00_0400, 0, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    miss_fill("refetchA", 32'h1C00_0000, 1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
  endtask

  task automatic test_ack_wait();
    miss_fill("ackwait", 32'h1C00_0010, 5, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
  endtask

  task automatic test_drop();
    int lat; bit rok; logic rdy; logic [31:0] ins;
    logic [127:0] d = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1C00_0020;
    serve_miss(32'h1C00_0020, 0, d, 1'b1, lat, rok, rdy, ins);
    n_tests++; if (lat != 6 || rdy !== 1'b0 || ins !== 32'h0) begin n_fail++; $display("FAIL drop_done got lat=%0d ready=%b inst=%h exp lat=6 ready=0 inst=0", lat, rdy, ins); end
    model_install(32'h1C00_0020, d);
    @(negedge clk); #1;
    n_tests++; if (stall !== 1'b0 || resp_ready !== 1'b0 || resp_inst !== 32'h0) begin n_fail++; $display("FAIL idle_novalid got stall=%b ready=%b inst=%h exp 0/0/0", stall, resp_ready, resp_inst); end
    expect_hit("drop_later", 32'h1C00_0024);
  endtask

  task automatic test_inval();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1C00_000C; inval = 1'b1;
    #1;
    n_tests++; if (resp_ready !== 1'b1 || resp_inst !== 32'hA3) begin n_fail++; $display("FAIL inval_same_cycle_hit got ready=%b inst=%h exp ready=1 inst=a3", resp_ready, resp_inst); end
    @(negedge clk);
    inval = 1'b0; req_valid = 1'b0;
    model_clear();
    miss_fill("after_inval", 32'h1C00_000C, 0, {32'hE3, 32'hE2, 32'hE1, 32'hE0});
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1C00_0030;
    @(negedge clk); mem_rd_ack = 1'b1;
    @(negedge clk); mem_rd_ack = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 32'hF0;
    @(negedge clk); mem_rd_valid = 1'b0; #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL refill_stall got=%b exp=1", stall); end
    rst = 1'b0; #1;
    n_tests++; if (mem_rd_req !== 1'b0 || stall !== 1'b0 || resp_ready !== 1'b0) begin n_fail++; $display("FAIL async_reset got req=%b stall=%b ready=%b exp 0/0/0", mem_rd_req, stall, resp_ready); end
    @(negedge clk); rst = 1'b1; req_valid = 1'b0;
    model_clear();
    miss_fill("after_rst", 32'h1C00_0000, 0, {32'hA7, 32'hA6, 32'hA5, 32'hA4});
  endtask

  task automatic test_random();
    logic [31:0] a; logic [127:0] d;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        @(negedge clk);
        req_valid = 1'b0; inval = 1'b1;
        #1;
        n_tests++; if (resp_ready !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rnd_idle got ready=%b stall=%b exp 0/0", resp_ready, stall); end
        @(negedge clk); inval = 1'b0;
        model_clear();
      end else begin
        a = 32'h1C00_0000 | (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
            | (32'($urandom_range(0, 3)) << 2);
        if (model_hit(a)) begin
          expect_hit("rnd", a);
        end else begin
          d = {$urandom, $urandom, $urandom, $urandom};
          miss_fill("rnd", a, int'($urandom_range(0, 3)), d);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_first_miss();
    test_hit();
    test_conflict();
    test_ack_wait();
    test_drop();
    test_inval();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
